lp_enum: RTL and testbench
==========================

LP_ENUM -- requirements
Module: lp_enum

Interface
REQ-001 SHALL provide parameter N_CON, default 6: number of constraint beats per problem (range 4..15).
REQ-002 SHALL provide parameter A_W, default 6: signed width of coefficients in_a1/in_a2.
REQ-003 SHALL provide parameter B_W, default 12: signed width of in_b and of the grid coordinates x/y.
REQ-004 SHALL provide clk  input  1: clock; all state changes on the rising edge.
REQ-005 SHALL provide rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL provide in_valid  input  1: input beat qualifier.
REQ-007 SHALL provide in_mode  input  1: 0 = maximise, 1 = minimise; sampled on beat 0 only.
REQ-008 SHALL provide in_a1, in_a2  input  A_W signed each: beat 0 carries objective c1/c2; beats 1..N_CON carry constraint coefficients.
REQ-009 SHALL provide in_b  input  B_W signed: constraint bound; ignored on beat 0.
REQ-010 SHALL provide busy  output  1: high from the cycle after beat 0 until the out_valid cycle, inclusive.
REQ-011 SHALL provide out_valid  output  1: single-cycle result strobe.
REQ-012 SHALL provide out_feasible  output  1: at least one integer grid point satisfies all constraints.
REQ-013 SHALL provide out_value  output  A_W+B_W+1 signed: optimal objective c1*x+c2*y.

Function
REQ-014 SHALL implement the states IDLE, LOAD, CHECK, ENUM and DONE.
REQ-015 IDLE: an in_valid beat is beat 0; capture c1, c2 and mode, then go to LOAD.
REQ-016 LOAD: accept N_CON consecutive beats, storing constraint k as a1*x + a2*y <= b.
REQ-017 LOAD: after the last beat, go to CHECK.
REQ-018 LOAD: if in_valid is low before N_CON beats, discard the problem, return to IDLE and emit no out_valid.
REQ-019 Axis bounds SHALL be extracted while loading, keeping the tightest of any duplicates: (1,0,b) gives x_hi=min(b); (-1,0,b) gives x_lo=max(-b); (0,1,b) gives y_hi=min(b); (0,-1,b) gives y_lo=max(-b).
REQ-020 CHECK takes 1 cycle: if any of the four bounds is absent, or x_lo>x_hi, or y_lo>y_hi, go to DONE with feasible=0.
REQ-021 Otherwise, CHECK SHALL set x=x_lo and y=y_lo and go to ENUM.
REQ-022 ENUM SHALL evaluate one grid point (x,y) per cycle against all N_CON constraints in parallel, axis constraints included.
REQ-023 Scan order SHALL be x inner and y outer: at x==x_hi, x<=x_lo and y<=y+1.
REQ-024 ENUM SHALL leave to DONE after evaluating (x_hi,y_hi).
REQ-025 Products and sums SHALL use A_W+B_W+1 signed arithmetic; b SHALL be sign-extended for comparison; no overflow or saturation is possible within these widths.
REQ-026 The first satisfying point SHALL initialise best and set feasible=1.
REQ-027 Each later satisfying point SHALL replace best if its objective is greater (mode 0) or less (mode 1); ties keep best.
REQ-028 Constraints with a1=a2=0 SHALL reduce to 0<=b and are legal.
REQ-029 DONE, 1 cycle: out_valid=1, out_feasible=feasible, out_value=best (0 if infeasible); then go to IDLE.
REQ-030 Outside the out_valid cycle, out_feasible and out_value SHALL be 0.
REQ-031 Latency: out_valid SHALL occur NPTS+2 cycles after the edge that samples the last beat, where NPTS=(x_hi-x_lo+1)*(y_hi-y_lo+1).
REQ-032 Latency on the CHECK-infeasible path SHALL be 2 cycles.
REQ-033 in_valid during CHECK, ENUM or DONE SHALL be ignored; the next problem's beat 0 is accepted no earlier than the cycle after out_valid.

Reset
REQ-034 Asserting rst_n low SHALL immediately force IDLE with busy=0, out_valid=0, out_feasible=0 and out_value=0.
REQ-035 Reset SHALL clear all bound-present flags, feasible and best.
REQ-036 Reset during LOAD or ENUM SHALL abandon the problem, and no out_valid SHALL follow.
REQ-037 The first beat after rst_n deasserts SHALL be treated as beat 0.

Verification
REQ-038 Max: mode 0, c=(1,1), constraints (1,0,3),(-1,0,0),(0,1,2),(0,-1,0),(1,1,4),(0,0,5) -> out_valid 14 cycles after the last beat, feasible=1, value=4.
REQ-039 Min: same problem with mode 1 -> feasible=1, value=0, same latency.
REQ-040 Empty box: (1,0,1),(-1,0,-3) plus a valid y pair and two (0,0,1) -> out_valid 2 cycles after the last beat, feasible=0, value=0.
REQ-041 Missing bound: no (0,1,b) constraint present -> 2-cycle infeasible result.
REQ-042 Duplicates and negatives: c=(-2,3), x in [-2,2] via (1,0,5),(1,0,2),(-1,0,2), y in [-1,1], one constraint (1,1,0) -> value=7 at (-2,1), NPTS=15.
REQ-043 Abort: drop in_valid after beat 3, then reset mid-ENUM on the next problem -> no out_valid, and outputs are 0 through reset.

Source files
------------

// File: rtl/lp_enum.sv
// lp_enum: two-variable integer linear program solved by brute-force grid scan.
// A problem is one objective beat followed by N_CON constraint beats. Axis
// constraints set the scan box; every grid point inside it is tested against
// all constraints and the best objective value is kept.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for beat 0 (objective and mode)
// LOAD  | accepting constraint beats, extracting axis bounds
// CHECK | one cycle: box present and non-empty? seed scan at (x_lo,y_lo)
// ENUM  | one grid point per cycle, x inner, y outer
// DONE  | one cycle: result is registered onto the outputs
module lp_enum #(
   parameter int N_CON = 6,
   parameter int A_W   = 6,
   parameter int B_W   = 12
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic                    in_mode,
   input  logic signed [A_W-1:0]   in_a1,
   input  logic signed [A_W-1:0]   in_a2,
   input  logic signed [B_W-1:0]   in_b,
   output logic                    busy,
   output logic                    out_valid,
   output logic                    out_feasible,
   output logic signed [A_W+B_W:0] out_value
);

   localparam int V_W = A_W + B_W + 1;
   // Bounds carry one extra bit so that -b of the most negative b is exact.
   localparam int X_W = B_W + 1;
   localparam int C_W = 4;

   localparam logic signed [A_W-1:0] A_P1 = A_W'(1);
   localparam logic signed [A_W-1:0] A_M1 = A_W'(-1);
   localparam logic signed [A_W-1:0] A_Z  = '0;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CHECK, S_ENUM, S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [C_W-1:0]        cnt_q, cnt_d;
   logic                  mode_q, mode_d;
   logic signed [A_W-1:0] c1_q, c1_d, c2_q, c2_d;
   logic signed [A_W-1:0] a1_q [N_CON];
   logic signed [A_W-1:0] a1_d [N_CON];
   logic signed [A_W-1:0] a2_q [N_CON];
   logic signed [A_W-1:0] a2_d [N_CON];
   logic signed [B_W-1:0] b_q  [N_CON];
   logic signed [B_W-1:0] b_d  [N_CON];
   logic signed [X_W-1:0] xlo_q, xlo_d, xhi_q, xhi_d, ylo_q, ylo_d, yhi_q, yhi_d;
   logic                  has_xlo_q, has_xlo_d, has_xhi_q, has_xhi_d;
   logic                  has_ylo_q, has_ylo_d, has_yhi_q, has_yhi_d;
   logic signed [B_W-1:0] x_q, x_d, y_q, y_d;
   logic                  feas_q, feas_d;
   logic signed [V_W-1:0] best_q, best_d;
   logic                  out_valid_q, out_valid_d, out_feas_q, out_feas_d;
   logic signed [V_W-1:0] out_value_q, out_value_d;

   logic                  accept, load_last, box_ok, pt_sat, pt_last, better;
   logic signed [V_W-1:0] obj;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         mode_q      <= 1'b0;
         c1_q        <= '0;
         c2_q        <= '0;
         for (int k = 0; k < N_CON; k++) begin
            a1_q[k] <= '0;
            a2_q[k] <= '0;
            b_q[k]  <= '0;
         end
         xlo_q       <= '0;
         xhi_q       <= '0;
         ylo_q       <= '0;
         yhi_q       <= '0;
         has_xlo_q   <= 1'b0;
         has_xhi_q   <= 1'b0;
         has_ylo_q   <= 1'b0;
         has_yhi_q   <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         feas_q      <= 1'b0;
         best_q      <= '0;
         out_valid_q <= 1'b0;
         out_feas_q  <= 1'b0;
         out_value_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         c1_q        <= c1_d;
         c2_q        <= c2_d;
         a1_q        <= a1_d;
         a2_q        <= a2_d;
         b_q         <= b_d;
         xlo_q       <= xlo_d;
         xhi_q       <= xhi_d;
         ylo_q       <= ylo_d;
         yhi_q       <= yhi_d;
         has_xlo_q   <= has_xlo_d;
         has_xhi_q   <= has_xhi_d;
         has_ylo_q   <= has_ylo_d;
         has_yhi_q   <= has_yhi_d;
         x_q         <= x_d;
         y_q         <= y_d;
         feas_q      <= feas_d;
         best_q      <= best_d;
         out_valid_q <= out_valid_d;
         out_feas_q  <= out_feas_d;
         out_value_q <= out_value_d;
      end
   end

   // Evaluate the current grid point against every constraint at once.
   always_comb begin
      logic signed [V_W-1:0] lhs;
      lhs    = '0;
      pt_sat = 1'b1;
      for (int k = 0; k < N_CON; k++) begin
         lhs = V_W'(a1_q[k]) * V_W'(x_q) + V_W'(a2_q[k]) * V_W'(y_q);
         if (lhs > V_W'(b_q[k])) pt_sat = 1'b0;
      end
      obj     = V_W'(c1_q) * V_W'(x_q) + V_W'(c2_q) * V_W'(y_q);
      better  = mode_q ? (obj < best_q) : (obj > best_q);
      pt_last = (X_W'(x_q) == xhi_q) && (X_W'(y_q) == yhi_q);
      box_ok  = has_xlo_q && has_xhi_q && has_ylo_q && has_yhi_q &&
                (xlo_q <= xhi_q) && (ylo_q <= yhi_q);
      // A result still on the outputs blocks the next beat 0 for that cycle.
      accept    = in_valid && !out_valid_q;
      load_last = (cnt_q == C_W'(N_CON - 1));
   end

   // Next values of the datapath registers.
   always_comb begin
      logic signed [X_W-1:0] bx, nbx;
      bx        = X_W'(in_b);
      nbx       = -bx;
      cnt_d     = cnt_q;
      mode_d    = mode_q;
      c1_d      = c1_q;
      c2_d      = c2_q;
      a1_d      = a1_q;
      a2_d      = a2_q;
      b_d       = b_q;
      xlo_d     = xlo_q;
      xhi_d     = xhi_q;
      ylo_d     = ylo_q;
      yhi_d     = yhi_q;
      has_xlo_d = has_xlo_q;
      has_xhi_d = has_xhi_q;
      has_ylo_d = has_ylo_q;
      has_yhi_d = has_yhi_q;
      x_d       = x_q;
      y_d       = y_q;
      feas_d    = feas_q;
      best_d    = best_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               mode_d    = in_mode;
               c1_d      = in_a1;
               c2_d      = in_a2;
               cnt_d     = '0;
               has_xlo_d = 1'b0;
               has_xhi_d = 1'b0;
               has_ylo_d = 1'b0;
               has_yhi_d = 1'b0;
               feas_d    = 1'b0;
               best_d    = '0;
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               for (int k = 0; k < N_CON; k++) begin
                  if (cnt_q == C_W'(k)) begin
                     a1_d[k] = in_a1;
                     a2_d[k] = in_a2;
                     b_d[k]  = in_b;
                  end
               end
               cnt_d = cnt_q + C_W'(1);
               if (in_a1 == A_P1 && in_a2 == A_Z && (!has_xhi_q || bx < xhi_q)) begin
                  xhi_d     = bx;
                  has_xhi_d = 1'b1;
               end
               if (in_a1 == A_M1 && in_a2 == A_Z && (!has_xlo_q || nbx > xlo_q)) begin
                  xlo_d     = nbx;
                  has_xlo_d = 1'b1;
               end
               if (in_a1 == A_Z && in_a2 == A_P1 && (!has_yhi_q || bx < yhi_q)) begin
                  yhi_d     = bx;
                  has_yhi_d = 1'b1;
               end
               if (in_a1 == A_Z && in_a2 == A_M1 && (!has_ylo_q || nbx > ylo_q)) begin
                  ylo_d     = nbx;
                  has_ylo_d = 1'b1;
               end
            end
         end
         S_CHECK: begin
            // A non-empty box has x_lo <= x_hi < 2^(B_W-1), so truncation is exact.
            x_d = xlo_q[B_W-1:0];
            y_d = ylo_q[B_W-1:0];
         end
         S_ENUM: begin
            if (pt_sat && (!feas_q || better)) begin
               best_d = obj;
               feas_d = 1'b1;
            end
            if (X_W'(x_q) == xhi_q) begin
               x_d = xlo_q[B_W-1:0];
               y_d = y_q + B_W'(1);
            end else begin
               x_d = x_q + B_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_LOAD;
         S_LOAD: begin
            if (!in_valid)      state_d = S_IDLE;
            else if (load_last) state_d = S_CHECK;
         end
         S_CHECK: state_d = box_ok ? S_ENUM : S_DONE;
         S_ENUM:  if (pt_last) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: result registered out of DONE, zero at all other times.
   always_comb begin
      busy         = (state_q != S_IDLE) || out_valid_q;
      out_valid    = out_valid_q;
      out_feasible = out_feas_q;
      out_value    = out_value_q;
      out_valid_d  = (state_q == S_DONE);
      out_feas_d   = (state_q == S_DONE) && feas_q;
      out_value_d  = ((state_q == S_DONE) && feas_q) ? best_q : '0;
   end

endmodule

// File: tb/tb_lp_enum.sv
// Testbench for lp_enum: directed problems, a bench-side brute-force solver
// and a per-cycle compare of out_valid/out_feasible/out_value/busy.
module tb_lp_enum;

   localparam int N_CON = 6;
   localparam int A_W   = 6;
   localparam int B_W   = 12;
   localparam int V_W   = A_W + B_W + 1;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  in_mode = 1'b0;
   logic signed [A_W-1:0] in_a1 = '0;
   logic signed [A_W-1:0] in_a2 = '0;
   logic signed [B_W-1:0] in_b = '0;
   logic                  busy, out_valid, out_feasible;
   logic signed [V_W-1:0] out_value;

   lp_enum #(.N_CON(N_CON), .A_W(A_W), .B_W(B_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_mode(in_mode),
      .in_a1(in_a1), .in_a2(in_a2), .in_b(in_b), .busy(busy),
      .out_valid(out_valid), .out_feasible(out_feasible), .out_value(out_value)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int     errors = 0;
   int     checks = 0;
   int     exp_cycle = -1;
   int     bz_start = -1;
   int     bz_end = -1;
   bit     exp_feas = 0;
   longint exp_val = 0;
   bit     done = 0;
   int     got_cycle = 0;
   bit     got_feas = 0;
   longint got_val = 0;

   int ca1 [N_CON];
   int ca2 [N_CON];
   int cb  [N_CON];
   int m_feas, m_val, m_lat;

   function automatic void chk(string name, longint act, longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference solver: bounds from the axis rows, then every box point.
   function automatic void model(int mode, int c1, int c2);
      int xlo, xhi, ylo, yhi, best, v;
      bit hxl, hxh, hyl, hyh, found, ok;
      hxl = 0; hxh = 0; hyl = 0; hyh = 0;
      xlo = 0; xhi = 0; ylo = 0; yhi = 0;
      for (int k = 0; k < N_CON; k++) begin
         if (ca1[k] == 1 && ca2[k] == 0) begin
            if (!hxh || cb[k] < xhi) xhi = cb[k];
            hxh = 1;
         end
         if (ca1[k] == -1 && ca2[k] == 0) begin
            if (!hxl || -cb[k] > xlo) xlo = -cb[k];
            hxl = 1;
         end
         if (ca1[k] == 0 && ca2[k] == 1) begin
            if (!hyh || cb[k] < yhi) yhi = cb[k];
            hyh = 1;
         end
         if (ca1[k] == 0 && ca2[k] == -1) begin
            if (!hyl || -cb[k] > ylo) ylo = -cb[k];
            hyl = 1;
         end
      end
      if (!(hxl && hxh && hyl && hyh) || xlo > xhi || ylo > yhi) begin
         m_feas = 0; m_val = 0; m_lat = 2;
         return;
      end
      m_lat = (xhi - xlo + 1) * (yhi - ylo + 1) + 2;
      found = 0; best = 0;
      for (int y = ylo; y <= yhi; y++) begin
         for (int x = xlo; x <= xhi; x++) begin
            ok = 1;
            for (int k = 0; k < N_CON; k++)
               if (ca1[k] * x + ca2[k] * y > cb[k]) ok = 0;
            if (ok) begin
               v = c1 * x + c2 * y;
               if (!found || (mode != 0 ? v < best : v > best)) best = v;
               found = 1;
            end
         end
      end
      m_feas = found ? 1 : 0;
      m_val  = found ? best : 0;
   endfunction

   // Per-cycle compare against the scheduled expectation.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_feasible", out_feasible, 0);
         chk("rst_out_value", out_value, 0);
         chk("rst_busy", busy, 0);
      end else begin
         chk("out_valid", out_valid, cyc == exp_cycle);
         chk("busy", busy, (cyc >= bz_start) && (cyc <= bz_end));
         if (out_valid) begin
            chk("out_feasible", out_feasible, exp_feas);
            chk("out_value", out_value, exp_val);
            done      = 1;
            got_cycle = cyc;
            got_feas  = out_feasible;
            got_val   = out_value;
         end else begin
            chk("idle_feasible", out_feasible, 0);
            chk("idle_value", out_value, 0);
         end
      end
   end

   task automatic beat(bit v, bit m, int a1, int a2, int b);
      in_valid = v;
      in_mode  = m;
      in_a1    = a1[A_W-1:0];
      in_a2    = a2[A_W-1:0];
      in_b     = b[B_W-1:0];
      @(posedge clk);
      #1;
   endtask

   task automatic run_prob(int mode, int c1, int c2, bit noise, output int lat);
      int last, n;
      exp_cycle = -1;
      done      = 0;
      got_cycle = 0;
      beat(1, mode[0], c1, c2, 1445);
      bz_start = cyc;
      bz_end   = 1 << 30;
      for (int k = 0; k < N_CON; k++) beat(1, 0, ca1[k], ca2[k], cb[k]);
      last = cyc;
      model(mode, c1, c2);
      exp_cycle = last + m_lat;
      exp_feas  = m_feas[0];
      exp_val   = m_val;
      bz_end    = exp_cycle;
      in_valid  = 0;
      n = 0;
      while (!done && n < m_lat + 20) begin
         if (noise) begin
            in_valid = 1;
            in_mode  = 1'($urandom);
            in_a1    = A_W'($urandom);
            in_a2    = A_W'($urandom);
            in_b     = B_W'($urandom);
         end
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 0;
      chk("result_seen", done, 1);
      lat = got_cycle - last;
   endtask

   int lat;

   initial begin
      rst_n = 0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1;
      @(posedge clk);
      #1;

      // Maximise x+y in [0,3]x[0,2] with x+y<=4.
      ca1 = '{1, -1, 0, 0, 1, 0};
      ca2 = '{0, 0, 1, -1, 1, 0};
      cb  = '{3, 0, 2, 0, 4, 5};
      run_prob(0, 1, 1, 0, lat);
      chk("max_lat", lat, 14);
      chk("max_feas", got_feas, 1);
      chk("max_val", got_val, 4);

      // Same problem minimised, with junk on in_valid while busy.
      run_prob(1, 1, 1, 1, lat);
      chk("min_lat", lat, 14);
      chk("min_feas", got_feas, 1);
      chk("min_val", got_val, 0);

      // Empty x range.
      ca1 = '{1, -1, 0, 0, 0, 0};
      ca2 = '{0, 0, 1, -1, 0, 0};
      cb  = '{1, -3, 2, 0, 1, 1};
      run_prob(0, 1, 1, 0, lat);
      chk("empty_lat", lat, 2);
      chk("empty_feas", got_feas, 0);
      chk("empty_val", got_val, 0);

      // No y upper bound.
      ca1 = '{1, -1, 0, 1, 0, 0};
      ca2 = '{0, 0, -1, 1, 0, 0};
      cb  = '{3, 0, 0, 4, 5, 5};
      run_prob(0, 1, 1, 0, lat);
      chk("missing_lat", lat, 2);
      chk("missing_feas", got_feas, 0);

      // Duplicate x bound, negative coordinates and coefficients.
      ca1 = '{1, 1, -1, 0, 0, 1};
      ca2 = '{0, 0, 0, 1, -1, 1};
      cb  = '{5, 2, 2, 1, 1, 0};
      run_prob(0, -2, 3, 1, lat);
      chk("dup_max_lat", lat, 17);
      chk("dup_max_val", got_val, 7);
      run_prob(1, -2, 3, 0, lat);
      chk("dup_min_lat", lat, 17);
      chk("dup_min_val", got_val, -5);

      // A zero-coefficient row with negative bound kills every point.
      ca1 = '{1, -1, 0, 0, 0, 0};
      ca2 = '{0, 0, 1, -1, 0, 0};
      cb  = '{1, 0, 1, 0, -1, 3};
      run_prob(0, 1, 1, 0, lat);
      chk("zero_row_lat", lat, 6);
      chk("zero_row_feas", got_feas, 0);

      // Abort in LOAD after three constraint beats.
      exp_cycle = -1;
      done      = 0;
      beat(1, 0, 1, 1, 0);
      bz_start = cyc;
      bz_end   = 1 << 30;
      for (int k = 0; k < 3; k++) beat(1, 0, 1, 0, 3);
      bz_end   = cyc;
      in_valid = 0;
      repeat (20) @(posedge clk);
      #1;
      chk("abort_no_valid", done, 0);

      // Reset in the middle of ENUM.
      ca1 = '{1, -1, 0, 0, 1, 0};
      ca2 = '{0, 0, 1, -1, 1, 0};
      cb  = '{3, 0, 2, 0, 4, 5};
      done = 0;
      beat(1, 0, 1, 1, 0);
      bz_start = cyc;
      bz_end   = 1 << 30;
      for (int k = 0; k < N_CON; k++) beat(1, 0, ca1[k], ca2[k], cb[k]);
      in_valid = 0;
      repeat (5) @(posedge clk);
      #2;
      rst_n    = 0;
      bz_start = -1;
      bz_end   = -1;
      #1;
      chk("rst_imm_busy", busy, 0);
      chk("rst_imm_valid", out_valid, 0);
      chk("rst_imm_value", out_value, 0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1;
      repeat (20) @(posedge clk);
      #1;
      chk("rst_no_valid", done, 0);

      // First beat after reset starts a fresh problem.
      run_prob(0, 1, 1, 0, lat);
      chk("post_rst_lat", lat, 14);
      chk("post_rst_val", got_val, 4);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
